// File: rtl/types_pkg.sv
// Shared display types: digit count, one segment byte, and the flattened
// multi-digit pattern word.
package types_pkg;
   localparam int DIGITS = 8;
   typedef logic [7:0]          byte_t;
   typedef logic [DIGITS*8-1:0] word_t;
endpackage

// File: rtl/refresh_tick.sv
// Free-running slot prescaler: cnt counts 0..DIV-1 and wraps, and tick marks
// the last clock of each slot.
module refresh_tick #(
   parameter int DIV = 2,
   parameter int CW  = 1
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] cnt,
   output logic          tick
);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else     cnt <= tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with per-slot dead time, per-digit and
// global blanking, and a frame-latched snapshot of the display patterns.
module seg_scan_driver
   import types_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int DIGIT_HZ  = 8_000,
   parameter int BLANK_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  word_t             display,
   input  logic [DIGITS-1:0] digit_en,
   input  logic              en,
   output logic [DIGITS-1:0] AN,
   output byte_t             CATHODE,
   output logic              frame_done
);
   localparam int DIV = CLK_HZ / DIGIT_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYC);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic {BLANK, SHOW} slot_t;
   localparam slot_t SLOT_RST = (BLANK_CYC > 0) ? BLANK : SHOW;

   generate
      if (DIV < 2 || BLANK_CYC >= DIV || DIGITS < 1) begin : g_bad_cfg
         $error("seg_scan_driver: need DIV>=2, BLANK_CYC<DIV and DIGITS>=1");
      end
   endgenerate

   logic [CW-1:0]     cnt, cnt_next;
   logic              tick;
   logic [IW-1:0]     idx, idx_next;
   word_t             snap, snap_next;
   slot_t             slot, slot_next;
   logic [DIGITS-1:0] an_next;
   byte_t             cath_next;
   logic              fd_next;

   refresh_tick #(.DIV(DIV), .CW(CW)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .cnt  (cnt),
      .tick (tick)
   );

   // Outputs are registered against the next cnt/idx so that they line up
   // with the counters in the same cycle instead of lagging by one.
   always_comb begin
      cnt_next = tick ? '0 : cnt + 1'b1;
      idx_next = idx;
      if (tick) idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      snap_next = (idx == '0 && slot == BLANK) ? display : snap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) slot <= SLOT_RST;
      else     slot <= slot_next;
   end

   always_comb begin
      slot_next = SHOW;
      if (BLANK_CYC > 0 && cnt_next < BLANK_C) slot_next = BLANK;
   end

   always_comb begin
      an_next   = '1;
      cath_next = 8'hFF;
      fd_next   = tick && (idx_next == '0);
      if (slot_next == SHOW && en && digit_en[idx_next]) begin
         an_next[idx_next] = 1'b0;
         cath_next         = snap_next[{idx_next, 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx        <= '0;
         snap       <= '1;
         AN         <= '1;
         CATHODE    <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         idx        <= idx_next;
         snap       <= snap_next;
         AN         <= an_next;
         CATHODE    <= cath_next;
         frame_done <= fd_next;
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: fixed scan vectors, masking/enable sequences,
// random stimulus against a cycle-number model, and async reset mid-slot.
module tb_seg_scan_driver;
   import types_pkg::*;

   localparam int DIVC  = 10;
   localparam int BLK   = 2;
   localparam int FRAME = DIVC * DIGITS;

   logic              clk = 1'b0;
   logic              rst;
   word_t             display;
   logic [DIGITS-1:0] digit_en;
   logic              en;
   logic [DIGITS-1:0] an;
   byte_t             cathode;
   logic              frame_done;

   int t, n_chk, n_pass, phase;
   word_t             disp_h [0:4095];
   logic [DIGITS-1:0] den_h  [0:4095];
   logic              en_h   [0:4095];

   typedef struct {
      int                cyc;
      logic [DIGITS-1:0] an;
      byte_t             cath;
      logic              fd;
   } vec_t;
   vec_t tbl [$];

   seg_scan_driver #(.CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYC(BLK)) dut (
      .clk        (clk),
      .rst        (rst),
      .display    (display),
      .digit_en   (digit_en),
      .en         (en),
      .AN         (an),
      .CATHODE    (cathode),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog t=%0d", t);
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
   endtask

   // Expected outputs from the cycle number since reset release and the
   // recorded input history.
   task automatic model(input int c, output logic [DIGITS-1:0] e_an,
                        output byte_t e_cath, output logic e_fd);
      int    pos  = c % DIVC;
      int    d    = (c / DIVC) % DIGITS;
      int    base = (c / FRAME) * FRAME;
      word_t w;
      e_an   = '1;
      e_cath = 8'hFF;
      e_fd   = (c != 0) && (c % FRAME == 0);
      if (pos >= BLK && en_h[c-1] && den_h[c-1][d]) begin
         w         = disp_h[base + 1];
         e_an[d]   = 1'b0;
         e_cath    = w[d*8 +: 8];
      end
   endtask

   function automatic word_t rand_word();
      word_t w;
      for (int i = 0; i < DIGITS; i++) w[i*8 +: 8] = 8'($urandom);
      return w;
   endfunction

   task automatic drive_check(input word_t d, input logic [DIGITS-1:0] de, input logic e);
      logic [DIGITS-1:0] e_an;
      byte_t             e_cath;
      logic              e_fd;
      display = d; digit_en = de; en = e;
      disp_h[t] = d; den_h[t] = de; en_h[t] = e;
      @(negedge clk);
      model(t, e_an, e_cath, e_fd);
      chk("an", 64'(an), 64'(e_an));
      chk("cathode", 64'(cathode), 64'(e_cath));
      chk("frame_done", 64'(frame_done), 64'(e_fd));
      if (phase == 1)
         foreach (tbl[i])
            if (tbl[i].cyc == t) begin
               chk("vec_an", 64'(an), 64'(tbl[i].an));
               chk("vec_cathode", 64'(cathode), 64'(tbl[i].cath));
               chk("vec_frame_done", 64'(frame_done), 64'(tbl[i].fd));
            end
      if (phase == 2 && (t % FRAME) >= 22 && (t % FRAME) <= 29) begin
         chk("mask_slot2_an", 64'(an), 64'hFF);
         chk("mask_slot2_cathode", 64'(cathode), 64'hFF);
      end
      if (phase == 2 && (t % FRAME) == 35) chk("mask_slot3_an", 64'(an), 64'hF7);
      if (phase == 3 && t >= 411) chk("en_off_an", 64'(an), 64'hFF);
      if (phase == 3 && (t % FRAME) == 0) chk("en_off_frame_done", 64'(frame_done), 64'h1);
      if (phase == 6 && (t == 2 || t == 9)) begin
         chk("post_rst_an", 64'(an), 64'hFE);
         chk("post_rst_cathode", 64'(cathode), 64'(d[7:0]));
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic cycle(input word_t d, input logic [DIGITS-1:0] de, input logic e);
      drive_check(d, de, e);
      advance();
   endtask

   task automatic release_rst();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      t   = 0;
   endtask

   word_t init_w, d;

   initial begin
      n_chk = 0; n_pass = 0; phase = 0; t = 0;
      rst = 1'b1; display = '0; digit_en = '1; en = 1'b1;
      for (int i = 0; i < DIGITS; i++) init_w[i*8 +: 8] = 8'h10 + 8'(i);

      tbl.push_back('{0,   8'hFF, 8'hFF, 1'b0});
      tbl.push_back('{1,   8'hFF, 8'hFF, 1'b0});
      tbl.push_back('{2,   8'hFE, 8'h10, 1'b0});
      tbl.push_back('{9,   8'hFE, 8'h10, 1'b0});
      tbl.push_back('{10,  8'hFF, 8'hFF, 1'b0});
      tbl.push_back('{12,  8'hFD, 8'h11, 1'b0});
      tbl.push_back('{19,  8'hFD, 8'h11, 1'b0});
      tbl.push_back('{32,  8'hF7, 8'h13, 1'b0});
      tbl.push_back('{36,  8'hF7, 8'h13, 1'b0});
      tbl.push_back('{72,  8'h7F, 8'h17, 1'b0});
      tbl.push_back('{80,  8'hFF, 8'hFF, 1'b1});
      tbl.push_back('{81,  8'hFF, 8'hFF, 1'b0});
      tbl.push_back('{82,  8'hFE, 8'h00, 1'b0});
      tbl.push_back('{152, 8'h7F, 8'h00, 1'b0});
      tbl.push_back('{160, 8'hFF, 8'hFF, 1'b1});

      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_an", 64'(an), 64'hFF);
      chk("reset_cathode", 64'(cathode), 64'hFF);
      chk("reset_frame_done", 64'(frame_done), 64'h0);
      rst = 1'b0;

      // basic scan, frame wrap and tearing (display zeroed at cycle 35)
      phase = 1;
      for (int c = 0; c < 170; c++) cycle((c < 35) ? init_w : '0, '1, 1'b1);

      phase = 2;
      d = rand_word();
      while (t < 410) begin
         if ($urandom_range(0, 15) == 0) d = rand_word();
         cycle(d, 8'b1111_1011, 1'b1);
      end

      phase = 3;
      while (t < 580) cycle(d, '1, 1'b0);

      phase = 4;
      while (t < 980) begin
         if ($urandom_range(0, 19) == 0) d = rand_word();
         cycle(d, 8'($urandom), ($urandom_range(0, 7) != 0));
      end

      // clean restart, then reset asserted in the middle of slot 4
      phase = 5;
      rst = 1'b1;
      #1;
      chk("rst_an", 64'(an), 64'hFF);
      chk("rst_cathode", 64'(cathode), 64'hFF);
      chk("rst_frame_done", 64'(frame_done), 64'h0);
      release_rst();
      d = rand_word();
      while (t < 45) cycle(d, '1, 1'b1);
      drive_check(d, '1, 1'b1);
      chk("mid_slot_an", 64'(an), 64'hEF);
      rst = 1'b1;
      #1;
      chk("async_rst_an", 64'(an), 64'hFF);
      chk("async_rst_cathode", 64'(cathode), 64'hFF);
      release_rst();

      phase = 6;
      d = rand_word();
      while (t < 30) cycle(d, '1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter DIGIT_HZ, default 8_000, digit-slot rate in Hz; DIV = CLK_HZ/DIGIT_HZ clocks per slot.
REQ-003 Parameter BLANK_CYC, default 16, dead-time clocks at the start of each slot.
REQ-004 clk  input  1  single clock; all flops on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 display  input  DIGITS*8  flattened cathode patterns, 8 bits per digit, digit i at bits [i*8+:8], active-low segments.
REQ-007 digit_en  input  DIGITS  per-digit enable; 0 blanks that digit.
REQ-008 en  input  1  global display enable; 0 blanks all digits.
REQ-009 AN  output  DIGITS  anode drive, active-low one-hot.
REQ-010 CATHODE  output  8 (byte_t)  segment drive, active-low.
REQ-011 frame_done  output  1  one-clock pulse when the scan wraps to digit 0.

Function
REQ-012 Prescaler cnt counts 0..DIV-1 and wraps; tick is asserted when cnt==DIV-1.
REQ-013 Digit index idx advances on tick and wraps from DIGITS-1 to 0.
REQ-014 Slot states: BLANK while cnt<BLANK_CYC, SHOW otherwise; with BLANK_CYC=0 every cycle is SHOW.
REQ-015 In BLANK: AN all ones and CATHODE 8'hFF.
REQ-016 In SHOW with en=1 and digit_en[idx]=1: AN has only bit idx low, and CATHODE equals snapshot digit idx.
REQ-017 In SHOW with en=0 or digit_en[idx]=0: AN all ones and CATHODE 8'hFF.
REQ-018 Snapshot register (DIGITS*8) loads display on every cycle with idx==0 in BLANK; it holds otherwise, so no tearing occurs within a frame.
REQ-019 AN, CATHODE and frame_done are flop outputs and align with the current cnt and idx; there are no combinational paths from inputs to outputs.
REQ-020 frame_done is high for exactly the one cycle in which idx==0 and cnt==0, except for the first cycle after reset.
REQ-021 en and digit_en take effect at the next SHOW cycle; they never stall cnt or idx.
REQ-022 Changes to display during a frame appear only after the next frame's digit-0 BLANK.
REQ-023 Elaboration fails if DIV<2, if BLANK_CYC>=DIV, or if DIGITS<1.

Reset
REQ-024 Reset values: cnt=0, idx=0, snapshot all ones, AN all ones, CATHODE 8'hFF, frame_done=0.
REQ-025 Reset asserted mid-slot blanks the outputs asynchronously; the scan restarts at digit 0, cnt 0 after release.

Structure
REQ-026 DIGITS, byte_t and word_t come from types_pkg; the block defines no new package types.
REQ-027 The slot-state enum (BLANK, SHOW) is local to the module.
REQ-028 Prescaler is one sub-module, refresh_tick, parameterised by DIV, with outputs cnt and tick.
REQ-029 Total RTL is 120-400 lines across seg_scan_driver and refresh_tick.

Verification
Common bench setup: CLK_HZ=1000, DIGIT_HZ=100 (DIV=10), BLANK_CYC=2, DIGITS=8.
REQ-030 Basic scan: release reset with display digit i = 8'h10+i and all enables high.
- Cycles 0-1: AN=8'hFF.
- Cycles 2-9: AN=8'hFE, CATHODE=8'h10.
- Cycles 12-19: AN=8'hFD, CATHODE=8'h11.
REQ-031 Wrap: after 80 cycles, idx returns to 0 and frame_done pulses once at cycle 80; the next pulse is at cycle 160.
REQ-032 Tearing: change display at cycle 35 to all 8'h00.
- Digits 3-7 of the current frame still show 8'h13..8'h17.
- The next frame shows 8'h00 on every digit.
REQ-033 Blanking mask: digit_en=8'b1111_1011 -> during slot 2, AN=8'hFF and CATHODE=8'hFF; other slots are unaffected.
REQ-034 Global enable: en=0 for one full frame -> AN=8'hFF throughout, and frame_done keeps pulsing every 80 cycles.
REQ-035 Reset mid-slot: assert rst at cycle 45.
- Outputs go to AN=8'hFF, CATHODE=8'hFF before the next edge.
- After release, digit 0 is shown at cycles 2-9 again.
